run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Parametrised run controller between the processor top level's START/DONE interface and the core (datapath plus controlpath). It detects a START request and latches a program selector. It holds the core in reset for a programmable number of cycles, then enables it, counts executed cycles, and raises DONE on HALT. It adds what the current top level lacks: multi-program entry points, restart/abort, a cycle counter and an optional watchdog.

Parameters:
PC_WIDTH, 10, width of START_PC
NUM_PROGS, 3, number of selectable programs (>=1)
SEL_WIDTH, 2, width of PROG_SEL (>= clog2(NUM_PROGS), min 1)
PROG_STRIDE, 256, START_PC = latched selector * PROG_STRIDE, truncated to PC_WIDTH
RESET_CYCLES, 2, cycles CORE_RESET is held per run (>=1)
CNT_WIDTH, 32, width of CYCLE_COUNT
TIMEOUT_CYCLES, 1000000, watchdog limit (used only with the optional feature)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
START  input  1  run request; rising edge is sampled
PROG_SEL  input  SEL_WIDTH  program index, sampled with the START edge
HALT  input  1  core halt indication
CORE_RESET  output  1  synchronous reset to core, active-high
CORE_EN  output  1  core clock-enable; core frozen when 0
START_PC  output  PC_WIDTH  entry PC for the core's PC reset value
BUSY  output  1  1 in RESET_CORE or RUN
DONE  output  1  sticky run-complete flag
CYCLE_COUNT  output  CNT_WIDTH  cycles executed in the current or last run
TIMEOUT  output  1  last run ended by watchdog

Behaviour:
- RESET_N low, asynchronous. State IDLE. CORE_RESET=1, CORE_EN=0, BUSY=0, DONE=0, TIMEOUT=0, CYCLE_COUNT=0, START_PC=0, selector=0, START history=0.
  - After RESET_N release, CORE_RESET stays 1 until the first run reaches RUN.
- Start event: START=1 this cycle and START=0 the previous registered cycle. Holding START high produces exactly one event.
- States: IDLE, RESET_CORE, RUN. All outputs are registered.
- IDLE:
  - CORE_EN=0. CORE_RESET=0 after any completed run, so core state stays inspectable.
  - DONE, TIMEOUT and CYCLE_COUNT hold their values.
  - Start event with PROG_SEL < NUM_PROGS: latch selector, load START_PC, clear DONE/TIMEOUT/CYCLE_COUNT, set reset counter to RESET_CYCLES, go to RESET_CORE.
  - Start event with PROG_SEL >= NUM_PROGS: ignored; nothing changes.
- RESET_CORE:
  - CORE_RESET=1, CORE_EN=0, BUSY=1.
  - Reset counter decrements each cycle. When it reaches 0, go to RUN.
  - CORE_RESET is high for exactly RESET_CYCLES cycles.
  - HALT is ignored.
- RUN:
  - CORE_RESET=0, CORE_EN=1, BUSY=1.
  - CYCLE_COUNT increments every RUN cycle, saturating at all-ones (never wraps).
  - HALT=1 in a RUN cycle: that cycle is counted. Next cycle: IDLE, DONE=1, CORE_EN=0.
- Latency: a start event sampled at edge t gives CORE_RESET=1 for cycles t+1..t+RESET_CYCLES. The first RUN cycle is t+RESET_CYCLES+1.
- Start event in RESET_CORE or RUN (including simultaneous with HALT): abort and restart.
  - Start wins over HALT.
  - New PROG_SEL is latched (if in range; otherwise the current run continues).
  - Counters are cleared, DONE stays 0, and the FSM re-enters RESET_CORE.
- START_PC is stable from the cycle after the start event until the next accepted start event.

Optional Feature:
Macro RUN_WATCHDOG_EN.
- Defined: in RUN, when CYCLE_COUNT equals TIMEOUT_CYCLES and HALT=0, go to IDLE next cycle with DONE=1 and TIMEOUT=1. HALT in that same cycle takes priority (TIMEOUT=0).
- Undefined: TIMEOUT is tied to 0, no comparator is built, and a run without HALT never ends.

Test Plan:
1. Basic run. Reset, then START edge with PROG_SEL=1, RESET_CYCLES=2, HALT on the 5th RUN cycle.
   -> CORE_RESET high exactly 2 cycles, START_PC=256, CORE_EN high 5 cycles, DONE=1, CYCLE_COUNT=5, BUSY=0.
   -> START held high afterwards triggers no second run.
2. Out-of-range select. PROG_SEL=3 with NUM_PROGS=3 in IDLE.
   -> no state change, DONE/CYCLE_COUNT keep prior values, CORE_RESET unchanged.
3. Abort. New START edge (PROG_SEL=2) in RUN cycle 7 with HALT also high.
   -> restart: CYCLE_COUNT=0, DONE stays 0, START_PC=512, CORE_RESET high 2 cycles.
4. Saturation. CNT_WIDTH=4, HALT after 20 RUN cycles.
   -> CYCLE_COUNT sticks at 15, DONE=1.
5. Watchdog. RUN_WATCHDOG_EN, TIMEOUT_CYCLES=20, no HALT.
   -> run ends with CYCLE_COUNT=20, DONE=1, TIMEOUT=1.
   -> Without the macro: still BUSY after 100 cycles, TIMEOUT=0.
6. Reset mid-run. RESET_N low mid-RUN, asynchronously between clock edges.
   -> all outputs at reset values immediately, state IDLE, CORE_RESET=1.

Source files
------------

// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//
// Run controller that sits between the processor top level's START/DONE
// interface and the core (datapath + controlpath).
//
// It detects a START rising edge and latches a program selector. It then
// holds the core in reset for RESET_CYCLES cycles and enables it. While the
// core runs, it counts executed cycles and raises a sticky DONE when the core
// reports HALT. A new START edge during a run aborts that run and restarts
// the sequence.
//
// Optional feature (macro RUN_WATCHDOG_EN):
//   When defined, a run without HALT ends once CYCLE_COUNT reaches
//   TIMEOUT_CYCLES. DONE and TIMEOUT are set in that case.
//   When undefined, TIMEOUT is constant 0 and no comparator is built.
//
// Interface semantics:
//   START is an edge request. An event is START=1 in this cycle and START=0
//   in the previous registered cycle, so a held START yields one event.
//   PROG_SEL is sampled together with that event. HALT is a level sampled in
//   every RUN cycle. The cycle in which HALT is seen still counts as
//   executed. There is no backpressure: every event is either accepted
//   (selector in range) or dropped (selector out of range).
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   START        run request (rising edge sampled)
//   PROG_SEL     program index, sampled with the START edge
//   HALT         core halt indication
//   CORE_RESET   synchronous active-high reset to the core
//   CORE_EN      core clock enable (core frozen when 0)
//   START_PC     entry PC = selector * PROG_STRIDE, truncated to PC_WIDTH
//   BUSY         1 while in RESET_CORE or RUN
//   DONE         sticky run-complete flag
//   CYCLE_COUNT  RUN cycles executed in the current or last run (saturating)
//   TIMEOUT      last run was ended by the watchdog
//   dbg_state    FSM state (0 IDLE, 1 RESET_CORE, 2 RUN)
//   dbg_sel      latched program selector
// -----------------------------------------------------------------------------
module run_sequencer #(
  parameter int PC_WIDTH       = 10,
  parameter int NUM_PROGS      = 3,
  parameter int SEL_WIDTH      = 2,
  parameter int PROG_STRIDE    = 256,
  parameter int RESET_CYCLES   = 2,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic [SEL_WIDTH-1:0] PROG_SEL,
  input  logic                 HALT,
  output logic                 CORE_RESET,
  output logic                 CORE_EN,
  output logic [PC_WIDTH-1:0]  START_PC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT,
  output logic                 TIMEOUT,
  output logic [1:0]           dbg_state,
  output logic [SEL_WIDTH-1:0] dbg_sel
);

  // The reset counter must be able to hold RESET_CYCLES itself.
  localparam int RST_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RESET_CORE = 2'd1,
    S_RUN        = 2'd2
  } state_t;

  state_t               state;
  logic                 start_q;   // START as registered in the previous cycle
  logic [SEL_WIDTH-1:0] sel_q;
  logic [RST_W-1:0]     rst_cnt;

  logic                 start_evt;
  logic                 sel_ok;
  logic                 accept;
  logic [PC_WIDTH-1:0]  pc_next;
  logic [CNT_WIDTH-1:0] cnt_next;

  assign start_evt = START & ~start_q;
  assign sel_ok    = (32'(PROG_SEL) < 32'(NUM_PROGS));
  assign accept    = start_evt & sel_ok;

  // Entry PC of the requested program. Wide product, then truncation, so that
  // strides beyond the PC range wrap just like the PC register would.
  assign pc_next = PC_WIDTH'(64'(PROG_SEL) * 64'(PROG_STRIDE));

  // Saturating increment: the counter sticks at all-ones and never wraps.
  assign cnt_next = (CYCLE_COUNT == {CNT_WIDTH{1'b1}}) ? CYCLE_COUNT
                                                       : CYCLE_COUNT + CNT_WIDTH'(1);

  assign dbg_state = state;
  assign dbg_sel   = sel_q;

`ifdef RUN_WATCHDOG_EN
  logic timeout_q;
  logic wd_hit;

  // The watchdog compares the cycles already executed. HALT seen in the same
  // cycle takes priority (see the RUN branch below).
  assign wd_hit  = (64'(CYCLE_COUNT) == 64'(TIMEOUT_CYCLES));
  assign TIMEOUT = timeout_q;
`else
  // The watchdog is not built. TIMEOUT is a constant 0, and the limit only
  // takes part in this constant expression.
  localparam bit WD_ACTIVE = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign TIMEOUT = WD_ACTIVE;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      sel_q       <= '0;
      rst_cnt     <= '0;
      CORE_RESET  <= 1'b1;   // core stays in reset until the first run reaches RUN
      CORE_EN     <= 1'b0;
      START_PC    <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      CYCLE_COUNT <= '0;
`ifdef RUN_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      start_q <= START;

      if (accept) begin
        // An accepted start event restarts from any state. It wins over HALT
        // in the same cycle, so an aborted run never reports DONE.
        state       <= S_RESET_CORE;
        sel_q       <= PROG_SEL;
        START_PC    <= pc_next;
        rst_cnt     <= RST_W'(RESET_CYCLES);
        CORE_RESET  <= 1'b1;
        CORE_EN     <= 1'b0;
        BUSY        <= 1'b1;
        DONE        <= 1'b0;
        CYCLE_COUNT <= '0;
`ifdef RUN_WATCHDOG_EN
        timeout_q   <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            // Hold everything. CORE_RESET stays low after a completed run so
            // the core state can still be inspected.
          end

          S_RESET_CORE: begin
            // The counter was loaded with RESET_CYCLES on the accepting edge.
            // Leaving on the count 1 -> 0 keeps CORE_RESET high for exactly
            // RESET_CYCLES cycles. HALT is ignored here.
            rst_cnt <= rst_cnt - RST_W'(1);
            if (rst_cnt == RST_W'(1)) begin
              state      <= S_RUN;
              CORE_RESET <= 1'b0;
              CORE_EN    <= 1'b1;
            end
          end

          S_RUN: begin
            if (HALT) begin
              // The halting cycle is itself counted.
              CYCLE_COUNT <= cnt_next;
              state       <= S_IDLE;
              CORE_EN     <= 1'b0;
              BUSY        <= 1'b0;
              DONE        <= 1'b1;
`ifdef RUN_WATCHDOG_EN
            end else if (wd_hit) begin
              // Stop with CYCLE_COUNT equal to the limit.
              state       <= S_IDLE;
              CORE_EN     <= 1'b0;
              BUSY        <= 1'b0;
              DONE        <= 1'b1;
              timeout_q   <= 1'b1;
`endif
            end else begin
              CYCLE_COUNT <= cnt_next;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_run_sequencer
//
// Self-checking bench for run_sequencer (default build, watchdog not built).
// CNT_WIDTH is reduced to 4 so that the saturation behaviour appears within
// short runs.
//
// The driver tasks issue runs and push the expected completion record into
// exp_q when they issue the halting stimulus. The record holds the entry PC,
// the saturated cycle count and the raw number of RUN cycles.
//
// A negedge monitor pops exp_q on every DONE rising edge and compares the
// record against the outputs. It also measures the CORE_RESET pulse length
// and the number of CORE_EN cycles of each run.
// -----------------------------------------------------------------------------
module tb_run_sequencer;

  localparam int PC_W    = 10;
  localparam int NPROG   = 3;
  localparam int SEL_W   = 2;
  localparam int STRIDE  = 256;
  localparam int RST_CYC = 2;
  localparam int CNT_W   = 4;
  localparam int EXP_W   = PC_W + CNT_W + 16;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             START = 1'b0;
  logic [SEL_W-1:0] PROG_SEL = '0;
  logic             HALT = 1'b0;
  logic             CORE_RESET;
  logic             CORE_EN;
  logic [PC_W-1:0]  START_PC;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] CYCLE_COUNT;
  logic             TIMEOUT;
  logic [1:0]       dbg_state;
  logic [SEL_W-1:0] dbg_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Model of what IDLE should show (last completed run, or reset values).
  logic             m_done       = 1'b0;
  logic [CNT_W-1:0] m_count      = '0;
  logic [PC_W-1:0]  m_pc         = '0;
  logic             m_core_reset = 1'b1;

  run_sequencer #(
    .PC_WIDTH     (PC_W),
    .NUM_PROGS    (NPROG),
    .SEL_WIDTH    (SEL_W),
    .PROG_STRIDE  (STRIDE),
    .RESET_CYCLES (RST_CYC),
    .CNT_WIDTH    (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .PROG_SEL    (PROG_SEL),
    .HALT        (HALT),
    .CORE_RESET  (CORE_RESET),
    .CORE_EN     (CORE_EN),
    .START_PC    (START_PC),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .CYCLE_COUNT (CYCLE_COUNT),
    .TIMEOUT     (TIMEOUT),
    .dbg_state   (dbg_state),
    .dbg_sel     (dbg_sel)
  );

  // ---------------- clock / global time limit ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [PC_W-1:0] pc_of(input int sel);
    return PC_W'((sel * STRIDE) % (1 << PC_W));
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int n);
    int max_v;
    max_v = (1 << CNT_W) - 1;
    return (n > max_v) ? CNT_W'(max_v) : CNT_W'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_edge(input int sel, input bit hold);
    START = 1'b0;
    tick();
    START    = 1'b1;
    PROG_SEL = SEL_W'(sel);
    tick();
    if (!hold) START = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int b;
    b  = 0;
    ok = 1'b1;
    while (!CORE_EN) begin
      if (b == 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_run: CORE_EN=%0b, required 1 within 20 cycles", CORE_EN);
        ok = 1'b0;
        return;
      end
      tick();
      b++;
    end
  endtask

  // n more RUN cycles, HALT in the last one; 'already' RUN cycles are done.
  task automatic run_to_halt(input int sel, input int already, input int n);
    int total;
    total = already + n;
    for (int k = 1; k <= n; k++) begin
      if (k == n) begin
        HALT = 1'b1;
        exp_q.push_back({pc_of(sel), sat(total), 16'(total)});
        m_done       = 1'b1;
        m_count      = sat(total);
        m_pc         = pc_of(sel);
        m_core_reset = 1'b0;
      end
      tick();
    end
    HALT = 1'b0;
  endtask

  task automatic do_run(input int sel, input int n);
    bit ok;
    start_edge(sel, 1'b0);
    wait_run(ok);
    if (ok) run_to_halt(sel, 0, n);
  endtask

  // Start program a, then at RUN cycle k raise a new START edge with selector
  // b (optionally with HALT). Finish with n2 RUN cycles ending in HALT.
  task automatic do_abort_run(input int a, input int k, input int b, input bit halt_ab, input int n2);
    bit ok;
    start_edge(a, 1'b0);
    wait_run(ok);
    if (!ok) return;
    repeat (k - 1) tick();
    START    = 1'b1;
    PROG_SEL = SEL_W'(b);
    HALT     = halt_ab;
    tick();
    HALT  = 1'b0;
    START = 1'b0;
    if (b < NPROG) begin
      check("abort_count", CYCLE_COUNT, 0);
      check("abort_done", DONE, 0);
      check("abort_core_reset", CORE_RESET, 1);
      check("abort_pc", START_PC, pc_of(b));
      wait_run(ok);
      if (ok) run_to_halt(b, 0, n2);
    end else begin
      check("badsel_run_busy", BUSY, 1);
      check("badsel_run_core_en", CORE_EN, 1);
      check("badsel_run_pc", START_PC, pc_of(a));
      check("badsel_run_count", CYCLE_COUNT, sat(k));
      run_to_halt(a, k, n2);
    end
  endtask

  // Out-of-range start event in IDLE: nothing may change.
  task automatic bad_sel_idle();
    start_edge(NPROG, 1'b0);
    repeat (3) tick();
    check("badsel_busy", BUSY, 0);
    check("badsel_core_en", CORE_EN, 0);
    check("badsel_done", DONE, m_done);
    check("badsel_count", CYCLE_COUNT, m_count);
    check("badsel_pc", START_PC, m_pc);
    check("badsel_core_reset", CORE_RESET, m_core_reset);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, CORE_RESET, 1);
    check({tag, "_core_en"}, CORE_EN, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_timeout"}, TIMEOUT, 0);
    check({tag, "_count"}, CYCLE_COUNT, 0);
    check({tag, "_pc"}, START_PC, 0);
    check({tag, "_state"}, dbg_state, 0);
    check({tag, "_sel"}, dbg_sel, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit done_prev  = 1'b0;
  bit rb_prev    = 1'b0;
  int rst_streak = 0;
  int en_run     = 0;

  always @(negedge CLK) begin
    logic [EXP_W-1:0] e;
    if (CORE_RESET && BUSY) rst_streak = rb_prev ? rst_streak + 1 : 1;
    if (CORE_RESET) en_run = 0;
    if (CORE_EN) en_run++;
    if (rb_prev && !(CORE_RESET && BUSY) && CORE_EN)
      check("core_reset_len", 64'(rst_streak), RST_CYC);
    if (DONE && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: DONE rose with count %0d, required no completion", CYCLE_COUNT);
      end else begin
        e = exp_q.pop_front();
        check("done_pc", START_PC, e[EXP_W-1 -: PC_W]);
        check("done_count", CYCLE_COUNT, e[16 +: CNT_W]);
        check("done_en_cycles", 64'(en_run), e[15:0]);
        check("done_busy", BUSY, 0);
        check("done_core_en", CORE_EN, 0);
        check("done_timeout", TIMEOUT, 0);
      end
    end
    rb_prev   = CORE_RESET && BUSY;
    done_prev = DONE;
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int b;

    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values("reset");
    RESET_N = 1'b1;
    repeat (3) tick();
    check("post_reset_core_reset", CORE_RESET, 1);
    check("post_reset_busy", BUSY, 0);

    bad_sel_idle();

    // Basic run: program 1, HALT on the 5th RUN cycle, START held afterwards.
    start_edge(1, 1'b1);
    wait_run(ok);
    if (ok) run_to_halt(1, 0, 5);
    check("basic_pc", START_PC, 256);
    check("basic_count", CYCLE_COUNT, 5);
    repeat (5) begin
      check("held_start_busy", BUSY, 0);
      check("held_start_done", DONE, 1);
      tick();
    end
    START = 1'b0;

    bad_sel_idle();

    // Abort in RUN cycle 7 with HALT also high; new program 2.
    do_abort_run(0, 7, 2, 1'b1, 4);

    // Saturation: 20 RUN cycles with a 4-bit counter.
    do_run(2, 20);
    check("sat_count", CYCLE_COUNT, 15);
    check("sat_done", DONE, 1);

    // Randomised runs, aborts and out-of-range requests.
    repeat (25) begin
      if ($urandom_range(0, 3) == 0) bad_sel_idle();
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, 3);
        do_abort_run($urandom_range(0, 2), $urandom_range(1, 8), b,
                     (b < NPROG) ? 1'($urandom_range(0, 1)) : 1'b0,
                     $urandom_range(1, 20));
      end else begin
        do_run($urandom_range(0, 2), $urandom_range(1, 22));
      end
    end

    // No watchdog: a run without HALT keeps going.
    start_edge(1, 1'b0);
    wait_run(ok);
    repeat (100) tick();
    check("nowd_busy", BUSY, 1);
    check("nowd_core_en", CORE_EN, 1);
    check("nowd_timeout", TIMEOUT, 0);
    check("nowd_count", CYCLE_COUNT, 15);

    // Asynchronous reset in the middle of a RUN cycle.
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge CLK);
    #2;
    RESET_N = 1'b1;
    m_done       = 1'b0;
    m_count      = '0;
    m_pc         = '0;
    m_core_reset = 1'b1;
    tick();
    check("after_async_core_reset", CORE_RESET, 1);
    check("after_async_busy", BUSY, 0);

    do_run(2, 3);
    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
